// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: FSM states and derived accumulator width.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } dot_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LEN   = 16;

  // Guard bits: summing up to len products of 2*w bits needs clog2(len) extra bits.
  function automatic int acc_width(input int w, input int len);
    return 2 * w + $clog2(len);
  endfunction

endpackage

// File: rtl/mult_dot_acc.sv
// Accumulates a run of booth_mult products into a signed dot product and
// presents it on a valid/ready port, holding off the upstream sequencer while it waits.
//  state   | meaning
//  ST_IDLE | no run open; stray mul_done is dropped
//  ST_ACC  | run open, summing products until len_q have arrived
//  ST_HOLD | finished sum on acc_out, waiting for acc_ready
module mult_dot_acc
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN   = DEFAULT_LEN,
  localparam int CNT_W = $clog2(LEN + 1),
  localparam int ACC_W = acc_width(WIDTH, LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_len,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_m,
  input  logic                    acc_ready,
  output logic                    acc_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    busy,
  output logic                    mul_hold,
  output logic                    drop_err
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  dot_state_t              r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]        r_len, w_len_nxt;
  logic                    r_drop, w_drop_nxt;

  logic [CNT_W-1:0]        w_len_clamp;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic                    w_open;

  assign w_len_clamp = (cfg_len > LEN_C) ? LEN_C : cfg_len;
  assign w_cnt_inc   = r_cnt + ONE_C;
  assign w_prod_ext  = {{(ACC_W-2*WIDTH){mul_m[2*WIDTH-1]}}, mul_m};

  // A new run opens from IDLE, or from HOLD when the handshake completes in the same cycle.
  assign w_open = start && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && acc_ready));

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_drop_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (mul_done && !start) w_drop_nxt = 1'b1;
      end
      ST_ACC: begin
        if (mul_done) begin
          w_acc_nxt = r_acc + w_prod_ext;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (acc_ready) w_state_nxt = ST_IDLE;
        if (mul_done && !w_open) w_drop_nxt = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_open) begin
      w_len_nxt = w_len_clamp;
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
      if (w_len_clamp == '0) begin
        w_state_nxt = ST_HOLD;
      end else if (mul_done) begin
        w_acc_nxt   = w_prod_ext;
        w_cnt_nxt   = ONE_C;
        w_state_nxt = (w_len_clamp == ONE_C) ? ST_HOLD : ST_ACC;
      end else begin
        w_state_nxt = ST_ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign acc_valid = (r_state == ST_HOLD);
  assign mul_hold  = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_ACC);
  assign acc_out   = r_acc;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_mult_dot_acc.sv
// Scoreboard bench for mult_dot_acc: products are modelled as plain integer a*b,
// expected sums are queued at issue time and popped by a handshake monitor.
module tb_mult_dot_acc;

  localparam int WIDTH = 8;
  localparam int LEN   = 16;
  localparam int CNT_W = 5;
  localparam int ACC_W = 20;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [CNT_W-1:0]        cfg_len;
  logic                    mul_done;
  logic [2*WIDTH-1:0]      mul_m;
  logic                    acc_ready;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_out;
  logic                    busy;
  logic                    mul_hold;
  logic                    drop_err;

  mult_dot_acc #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .mul_done(mul_done), .mul_m(mul_m), .acc_ready(acc_ready),
    .acc_valid(acc_valid), .acc_out(acc_out), .busy(busy),
    .mul_hold(mul_hold), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_fail = 0;
  int     drop_exp = 0;
  int     drop_seen = 0;
  longint exp_q[$];
  int     op_a[16];
  int     op_b[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: every accepted result must match the oldest expected sum.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid && acc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", longint'(acc_out), -1);
        end else begin
          check("result", longint'(acc_out), exp_q.pop_front());
        end
      end
      if (drop_err) drop_seen++;
    end
  end

  // mode 0: issue start; 1: start already issued by the handshake; 2: first product with start
  task automatic do_run(input int len, input int gap_max, input int mode);
    int     n;
    int     first;
    longint s;
    n = (len > LEN) ? LEN : len;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(op_a[i] * op_b[i]);
    exp_q.push_back(s);
    first = 0;
    if (mode != 1) begin
      start   = 1'b1;
      cfg_len = CNT_W'(len);
      if (mode == 2 && n > 0) begin
        mul_done = 1'b1;
        mul_m    = 16'(op_a[0] * op_b[0]);
        first    = 1;
      end
      tick();
      start    = 1'b0;
      mul_done = 1'b0;
    end
    for (int i = first; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      check("busy_in_run", busy, 1);
      if (i == n - 1) check("valid_before_last", acc_valid, 0);
      mul_done = 1'b1;
      mul_m    = 16'(op_a[i] * op_b[i]);
      tick();
      mul_done = 1'b0;
    end
    check("valid_latency", acc_valid, 1);
    check("mul_hold", mul_hold, 1);
  endtask

  task automatic hs(input int stall, input bit nstart, input int nlen, input bit inj);
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", acc_valid, 1);
      if (exp_q.size() > 0) check("hold_stable", longint'(acc_out), exp_q[0]);
      if (inj && $urandom_range(0, 1) == 1) begin
        mul_done = 1'b1;
        mul_m    = 16'($urandom);
        drop_exp++;
      end
      tick();
      mul_done = 1'b0;
    end
    acc_ready = 1'b1;
    start     = nstart;
    cfg_len   = CNT_W'(nlen);
    tick();
    acc_ready = 1'b0;
    start     = 1'b0;
  endtask

  task automatic fill_const(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin
      op_a[i] = a;
      op_b[i] = b;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = int'($urandom_range(0, 255)) - 128;
      op_b[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b2b;
    int len;
    int nlen;
    rst = 1'b1; start = 1'b0; cfg_len = '0; mul_done = 1'b0; mul_m = '0; acc_ready = 1'b0;
    #1;
    check("rst_valid", acc_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", mul_hold, 0);
    check("rst_acc", longint'(acc_out), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // stray product in IDLE
    mul_done = 1'b1; mul_m = 16'd5;
    tick();
    mul_done = 1'b0;
    drop_exp++;
    check("drop_idle", drop_err, 1);
    tick();
    check("drop_idle_clear", drop_err, 0);

    // 3*4 + -5*7 + 127*127
    op_a[0] = 3; op_b[0] = 4; op_a[1] = -5; op_b[1] = 7; op_a[2] = 127; op_b[2] = 127;
    do_run(3, 1, 0);
    hs(3, 0, 0, 0);

    fill_const(16, -128, -128);
    do_run(16, 1, 0);
    hs(2, 0, 0, 0);
    fill_const(16, 127, -128);
    do_run(16, 0, 0);
    hs(1, 0, 0, 0);

    // zero-length run, then a dropped product in HOLD
    do_run(0, 0, 0);
    check("len0_acc", longint'(acc_out), 0);
    mul_done = 1'b1; mul_m = 16'h1234;
    tick();
    mul_done = 1'b0;
    drop_exp++;
    check("drop_hold", drop_err, 1);
    check("drop_hold_acc", longint'(acc_out), 0);
    check("drop_hold_valid", acc_valid, 1);
    tick();
    check("drop_hold_clear", drop_err, 0);
    hs(0, 0, 0, 0);

    // back-to-back handshake with start
    op_a[0] = 1; op_b[0] = 1; op_a[1] = 2; op_b[1] = 3;
    do_run(2, 0, 0);
    hs(5, 1, 2, 0);
    check("b2b_busy", busy, 1);
    check("b2b_valid", acc_valid, 0);
    op_a[0] = 2; op_b[0] = 2; op_a[1] = 1; op_b[1] = -1;
    do_run(2, 0, 1);
    hs(0, 0, 0, 0);

    // product coincident with start
    op_a[0] = 10; op_b[0] = 10; op_a[1] = -1; op_b[1] = 1;
    do_run(2, 0, 2);
    hs(1, 0, 0, 0);

    // cfg_len above LEN clamps to LEN
    fill_rand();
    do_run(20, 0, 0);
    hs(0, 0, 0, 0);

    // reset mid-run: no result expected from the aborted run
    start = 1'b1; cfg_len = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mul_done = 1'b1; mul_m = 16'(i + 3);
      tick();
      mul_done = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_valid", acc_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_hold", mul_hold, 0);
    check("abort_drop", drop_err, 0);
    check("abort_acc", longint'(acc_out), 0);
    tick();
    rst = 1'b0;
    tick();
    op_a[0] = 6; op_b[0] = 7;
    do_run(1, 0, 0);
    hs(0, 0, 0, 0);

    // randomized runs with backpressure, stray products and back-to-back starts
    b2b = 1'b0;
    len = $urandom_range(0, 18);
    for (int it = 0; it < 25; it++) begin
      bit nb;
      fill_rand();
      do_run(len, 2, b2b ? 1 : 0);
      nb   = (it < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      nlen = $urandom_range(0, 18);
      hs($urandom_range(0, 3), nb, nlen, 1);
      b2b = nb;
      len = nlen;
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    check("drop_count", drop_seen, drop_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
